onehot_cnt: RTL and testbench



---
 rtl/watch_pkg.sv | 17 +
 rtl/onehot_dec.sv | 22 ++
 rtl/onehot_cnt.sv | 81 ++++++++
 tb/tb_onehot_cnt.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared constants and helpers for the stopwatch digit chain.
package watch_pkg;

  localparam int N_DIGIT = 10;
  localparam int W_DIGIT = 4;

  // Smallest r such that 2**r >= value; used to size binary index ports.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder; out-of-range indices decode to bit 0.
module onehot_dec #(
  parameter int N = 10,
  parameter int W = 4
) (
  input  logic [W-1:0] i_bin,
  output logic [N-1:0] o_onehot
);

  logic w_in_range;

  assign w_in_range = (32'(i_bin) < N);

  always_comb begin
    o_onehot = '0;
    for (int k = 0; k < N; k++) begin
      o_onehot[k] = (32'(i_bin) == k);
    end
    if (!w_in_range) o_onehot[0] = 1'b1;
  end

endmodule

// File: rtl/onehot_cnt.sv
// Registered one-hot position counter with wrap/saturate, load and a
// combinational terminal-count strobe for cascading digits.
module onehot_cnt
  import watch_pkg::*;
#(
  parameter int N       = N_DIGIT,
  parameter int W       = W_DIGIT,
  parameter int WRAP    = 1,
  parameter int RST_POS = 0
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         CE,
  input  logic         UP,
  input  logic         LOAD,
  input  logic [W-1:0] LOAD_VAL,
  output logic [W-1:0] BIN,
  output logic [N-1:0] ONE_HOT,
  output logic         TC
);

  if (N < 2 || W < clog2(N) || RST_POS < 0 || RST_POS >= N) begin : g_bad_param
    $error("onehot_cnt: illegal parameters N=%0d W=%0d RST_POS=%0d", N, W, RST_POS);
  end

  localparam logic [W-1:0] LAST    = W'(N - 1);
  localparam logic [W-1:0] FIRST   = '0;
  localparam logic [W-1:0] RST_BIN = W'(RST_POS);
  localparam logic [N-1:0] RST_OH  = N'(1) << RST_POS;

  logic [W-1:0] r_bin;
  logic [N-1:0] r_onehot;
  logic [W-1:0] w_next_bin;
  logic [N-1:0] w_next_oh;
  logic         w_at_last;
  logic         w_at_first;
  logic         w_load_ok;

  assign w_at_last  = (r_bin == LAST);
  assign w_at_first = (r_bin == FIRST);
  assign w_load_ok  = (32'(LOAD_VAL) < N);

  // Wrap targets are chosen explicitly since 2**W may exceed N.
  always_comb begin
    w_next_bin = r_bin;
    if (LOAD) begin
      w_next_bin = w_load_ok ? LOAD_VAL : FIRST;
    end else if (CE) begin
      if (UP) begin
        if (w_at_last) w_next_bin = (WRAP != 0) ? FIRST : LAST;
        else           w_next_bin = r_bin + W'(1);
      end else begin
        if (w_at_first) w_next_bin = (WRAP != 0) ? LAST : FIRST;
        else            w_next_bin = r_bin - W'(1);
      end
    end
  end

  onehot_dec #(
    .N(N),
    .W(W)
  ) u_dec (
    .i_bin   (w_next_bin),
    .o_onehot(w_next_oh)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_bin    <= RST_BIN;
      r_onehot <= RST_OH;
    end else begin
      r_bin    <= w_next_bin;
      r_onehot <= w_next_oh;
    end
  end

  assign BIN     = r_bin;
  assign ONE_HOT = r_onehot;
  assign TC      = CE & ~LOAD & ((UP & w_at_last) | (~UP & w_at_first));

endmodule

// File: tb/tb_onehot_cnt.sv
// Directed bench for onehot_cnt across wrap, saturate, non-power-of-two and wide configurations.
module tb_onehot_cnt;

  logic       clk;
  logic       rst;
  logic       ce;
  logic       up;
  logic       load;
  logic [5:0] ld6;

  logic [3:0]  a_bin;
  logic [9:0]  a_oh;
  logic        a_tc;
  logic [3:0]  b_bin;
  logic [9:0]  b_oh;
  logic        b_tc;
  logic [2:0]  c_bin;
  logic [5:0]  c_oh;
  logic        c_tc;
  logic [5:0]  d_bin;
  logic [59:0] d_oh;
  logic        d_tc;

  int total;
  int bad;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  onehot_cnt #(.N(10), .W(4), .WRAP(1), .RST_POS(0)) dut_a (
    .CLK(clk), .RESET(rst), .CE(ce), .UP(up), .LOAD(load), .LOAD_VAL(ld6[3:0]),
    .BIN(a_bin), .ONE_HOT(a_oh), .TC(a_tc)
  );
  onehot_cnt #(.N(10), .W(4), .WRAP(0), .RST_POS(0)) dut_b (
    .CLK(clk), .RESET(rst), .CE(ce), .UP(up), .LOAD(load), .LOAD_VAL(ld6[3:0]),
    .BIN(b_bin), .ONE_HOT(b_oh), .TC(b_tc)
  );
  onehot_cnt #(.N(6), .W(3), .WRAP(1), .RST_POS(0)) dut_c (
    .CLK(clk), .RESET(rst), .CE(ce), .UP(up), .LOAD(load), .LOAD_VAL(ld6[2:0]),
    .BIN(c_bin), .ONE_HOT(c_oh), .TC(c_tc)
  );
  onehot_cnt #(.N(60), .W(6), .WRAP(1), .RST_POS(0)) dut_d (
    .CLK(clk), .RESET(rst), .CE(ce), .UP(up), .LOAD(load), .LOAD_VAL(ld6),
    .BIN(d_bin), .ONE_HOT(d_oh), .TC(d_tc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_inv();
    chk("a_oh_inv", 64'(a_oh), 64'd1 << a_bin);
    chk("a_range", 64'(a_bin < 4'd10), 64'd1);
    chk("b_oh_inv", 64'(b_oh), 64'd1 << b_bin);
    chk("c_oh_inv", 64'(c_oh), 64'd1 << c_bin);
    chk("c_range", 64'(c_bin < 3'd6), 64'd1);
    chk("d_oh_inv", 64'(d_oh), 64'd1 << d_bin);
    chk("d_range", 64'(d_bin < 6'd60), 64'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_inv();
  endtask

  initial begin
    int p;
    int m;
    logic mtc;
    total = 0;
    bad   = 0;
    ce    = 1'b0;
    up    = 1'b0;
    load  = 1'b0;
    ld6   = '0;
    rst   = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    chk("rst_a_bin", 64'(a_bin), 64'd0);
    chk("rst_a_oh", 64'(a_oh), 64'h1);
    chk("rst_tc_ce0", 64'(a_tc), 64'd0);
    ce = 1'b1; up = 1'b0;
    #1 chk("rst_tc_down", 64'(a_tc), 64'd1);
    ce = 1'b0;
    #2 rst = 1'b0;

    // load 7: in range for a and d, out of range for the 6-position counter
    load = 1'b1; ld6 = 6'd7;
    tick();
    chk("ld7_a_bin", 64'(a_bin), 64'd7);
    chk("ld7_a_oh", 64'(a_oh), 64'h80);
    chk("ld7_c_bin", 64'(c_bin), 64'd0);
    chk("ld7_c_oh", 64'(c_oh), 64'h1);
    chk("ld7_d_bin", 64'(d_bin), 64'd7);
    load = 1'b0;

    // async reset mid-cycle, no clock edge
    #3 rst = 1'b1;
    #1;
    chk("async_a_bin", 64'(a_bin), 64'd0);
    chk("async_a_oh", 64'(a_oh), 64'h1);
    chk("async_d_bin", 64'(d_bin), 64'd0);
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_a_bin", 64'(a_bin), 64'd0);
      chk("hold_a_oh", 64'(a_oh), 64'h1);
    end

    // out-of-range load
    load = 1'b1; ld6 = 6'd5;
    tick();
    chk("ld5_a_bin", 64'(a_bin), 64'd5);
    ld6 = 6'd12;
    tick();
    chk("ld12_a_bin", 64'(a_bin), 64'd0);
    chk("ld12_a_oh", 64'(a_oh), 64'h1);
    chk("ld12_d_bin", 64'(d_bin), 64'd12);

    // up count: a wraps at 10, b saturates at 9, c wraps at 6
    ld6 = 6'd0;
    tick();
    load = 1'b0; ce = 1'b1; up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      #1;
      chk("up_a_tc", 64'(a_tc), 64'(((i - 1) % 10) == 9));
      chk("up_b_tc", 64'(b_tc), 64'(((i - 1) < 9 ? (i - 1) : 9) == 9));
      chk("up_c_tc", 64'(c_tc), 64'(((i - 1) % 6) == 5));
      tick();
      chk("up_a_bin", 64'(a_bin), 64'(i % 10));
      chk("up_a_oh", 64'(a_oh), 64'd1 << (i % 10));
      chk("up_b_bin", 64'(b_bin), 64'(i < 9 ? i : 9));
      chk("up_c_bin", 64'(c_bin), 64'(i % 6));
    end

    // down-saturate on b
    ce = 1'b0; load = 1'b1; ld6 = 6'd2;
    tick();
    chk("dn_b_ld", 64'(b_bin), 64'd2);
    load = 1'b0; ce = 1'b1; up = 1'b0;
    p = 2;
    for (int i = 0; i < 4; i++) begin
      #1 chk("dn_b_tc", 64'(b_tc), 64'(p == 0));
      tick();
      p = (p == 0) ? 0 : p - 1;
      chk("dn_b_bin", 64'(b_bin), 64'(p));
      chk("dn_b_oh", 64'(b_oh), 64'd1 << p);
    end
    #1 chk("dn_b_tc_end", 64'(b_tc), 64'd1);

    // load beats count enable at the boundary
    ce = 1'b0; load = 1'b1; ld6 = 6'd9;
    tick();
    chk("conf_a_ld9", 64'(a_bin), 64'd9);
    ce = 1'b1; up = 1'b1; ld6 = 6'd3;
    #1 chk("conf_a_tc", 64'(a_tc), 64'd0);
    tick();
    chk("conf_a_bin", 64'(a_bin), 64'd3);
    chk("conf_a_oh", 64'(a_oh), 64'h8);

    // wide counter boundary
    ce = 1'b0; ld6 = 6'd58;
    tick();
    chk("d_ld58", 64'(d_bin), 64'd58);
    load = 1'b0; ce = 1'b1; up = 1'b1;
    #1 chk("d_tc58", 64'(d_tc), 64'd0);
    tick();
    chk("d_bin59", 64'(d_bin), 64'd59);
    #1 chk("d_tc59", 64'(d_tc), 64'd1);
    tick();
    chk("d_wrap_bin", 64'(d_bin), 64'd0);
    chk("d_wrap_oh", 64'(d_oh), 64'h1);
    up = 1'b0;
    #1 chk("d_tc0_dn", 64'(d_tc), 64'd1);
    tick();
    chk("d_dnwrap_bin", 64'(d_bin), 64'd59);
    chk("d_dnwrap_oh", 64'(d_oh), 64'd1 << 59);

    // random CE/UP/LOAD against a reference model of dut_a
    ce = 1'b0; load = 1'b1; ld6 = 6'd4;
    tick();
    chk("rnd_a_start", 64'(a_bin), 64'd4);
    m = 4;
    for (int i = 0; i < 200; i++) begin
      ce   = 1'($urandom_range(0, 1));
      up   = 1'($urandom_range(0, 1));
      load = ($urandom_range(0, 7) == 0);
      ld6  = 6'($urandom_range(0, 63));
      #1;
      mtc = ce && !load && ((up && m == 9) || (!up && m == 0));
      chk("rnd_a_tc", 64'(a_tc), 64'(mtc));
      if (load)    m = (int'(ld6[3:0]) < 10) ? int'(ld6[3:0]) : 0;
      else if (ce) m = up ? ((m == 9) ? 0 : m + 1) : ((m == 0) ? 9 : m - 1);
      tick();
      chk("rnd_a_bin", 64'(a_bin), 64'(m));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
